// File: rtl/pixel_operand_sel_pipe.sv
// ---------------------------------------------------------------------------
// pixel_operand_sel_pipe
//
// Registered, multi-lane operand selector for the SIMD pixel ALU. Each lane
// of the operand vector is taken from the pixel lanes, the broadcast low
// byte of the immediate, a per-lane immediate byte, or the writeback
// forwarding bus. Selected vectors are held in a 2-entry skid buffer
// (head = operand_out register, skid = second entry). This lets the ALU
// stall without losing operands, and keeps in_ready free of any
// combinational path from out_ready.
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   in_valid     in   upstream operand request valid
//   in_ready     out  block can accept this cycle (registered)
//   sel_mode     in   00 pixel, 01 imm broadcast, 10 imm per-lane, 11 forward
//   pixel_in     in   pixel lanes, lane i = [i*PIXEL_W +: PIXEL_W]
//   immediate    in   instruction immediate
//   fwd_data     in   writeback bypass lanes
//   out_valid    out  operand_out valid (registered)
//   out_ready    in   ALU accepts operand_out
//   operand_out  out  selected operand vector (head entry, registered)
//   xfer_count   out  count of accepted requests, wraps modulo 2^CNT_W
// ---------------------------------------------------------------------------
module pixel_operand_sel_pipe #(
  parameter int PIXEL_W = 8,
  parameter int LANES   = 4,
  parameter int IMM_W   = 32,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [1:0]                 sel_mode,
  input  logic [LANES*PIXEL_W-1:0]   pixel_in,
  input  logic [IMM_W-1:0]           immediate,
  input  logic [LANES*PIXEL_W-1:0]   fwd_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES*PIXEL_W-1:0]   operand_out,
  output logic [CNT_W-1:0]           xfer_count
);

  localparam int VEC_W     = LANES * PIXEL_W;
  // Number of whole pixel-sized bytes in the immediate; per-lane mode
  // cycles through them when there are more lanes than immediate bytes.
  localparam int IMM_LANES = IMM_W / PIXEL_W;

  // The immediate must split into whole lanes.
  generate
    if ((IMM_W % PIXEL_W) != 0 || IMM_W < PIXEL_W) begin : g_bad_imm_w
      $error("IMM_W must be a non-zero multiple of PIXEL_W");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b10
  } state_t;

  state_t             state;
  state_t             next_state;

  logic               accept;
  logic               drain;
  logic [VEC_W-1:0]   sel_vec;
  logic [VEC_W-1:0]   skid;

  logic               head_load_new;
  logic               head_load_skid;
  logic               skid_load;
  logic               in_ready_next;
  logic               out_valid_next;

  // Both handshakes use registered flags only, so in_ready never depends
  // combinationally on out_ready.
  assign accept = in_valid & in_ready;
  assign drain  = out_valid & out_ready;

  // Lane operand selection, sampled into the buffer only on accept.
  always_comb begin
    sel_vec = '0;
    for (int i = 0; i < LANES; i++) begin
      case (sel_mode)
        2'b00:   sel_vec[i*PIXEL_W +: PIXEL_W] = pixel_in[i*PIXEL_W +: PIXEL_W];
        2'b01:   sel_vec[i*PIXEL_W +: PIXEL_W] = immediate[PIXEL_W-1:0];
        2'b10:   sel_vec[i*PIXEL_W +: PIXEL_W] = immediate[(i % IMM_LANES)*PIXEL_W +: PIXEL_W];
        // 2'b11: writeback forwarding bus
        default: sel_vec[i*PIXEL_W +: PIXEL_W] = fwd_data[i*PIXEL_W +: PIXEL_W];
      endcase
    end
  end

  // Buffer occupancy state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_EMPTY;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: occupancy moves by +1 on accept-only, -1 on drain-only.
  always_comb begin
    next_state = state;
    case (state)
      ST_EMPTY: begin
        if (accept) begin
          next_state = ST_ONE;
        end else begin
          next_state = ST_EMPTY;
        end
      end
      ST_ONE: begin
        if (accept && !drain) begin
          next_state = ST_TWO;
        end else if (!accept && drain) begin
          next_state = ST_EMPTY;
        end else begin
          next_state = ST_ONE;
        end
      end
      ST_TWO: begin
        if (drain) begin
          next_state = ST_ONE;
        end else begin
          next_state = ST_TWO;
        end
      end
      default: begin
        next_state = ST_EMPTY;
      end
    endcase
  end

  // Output/control decode: datapath load enables and next handshake flags.
  always_comb begin
    head_load_new  = 1'b0;
    head_load_skid = 1'b0;
    skid_load      = 1'b0;
    // Flags follow the state being entered so that they line up with it
    // from the very next cycle.
    in_ready_next  = (next_state != ST_TWO);
    out_valid_next = (next_state != ST_EMPTY);
    case (state)
      ST_EMPTY: begin
        head_load_new = accept;
      end
      ST_ONE: begin
        if (accept && drain) begin
          // Head is leaving this cycle, so the new vector replaces it.
          head_load_new = 1'b1;
        end else if (accept) begin
          // Head is stalled; park the new vector behind it.
          skid_load = 1'b1;
        end else begin
          head_load_new = 1'b0;
        end
      end
      ST_TWO: begin
        head_load_skid = drain;
      end
      default: begin
        head_load_new  = 1'b0;
        head_load_skid = 1'b0;
        skid_load      = 1'b0;
      end
    endcase
  end

  // Registered handshake flags; in_ready rises on the first edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      in_ready  <= in_ready_next;
      out_valid <= out_valid_next;
    end
  end

  // Head entry; holds while stalled and keeps its last value when empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      operand_out <= '0;
    end else if (head_load_new) begin
      operand_out <= sel_vec;
    end else if (head_load_skid) begin
      operand_out <= skid;
    end else begin
      operand_out <= operand_out;
    end
  end

  // Skid entry, written only when the head is occupied and stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid <= '0;
    end else if (skid_load) begin
      skid <= sel_vec;
    end else begin
      skid <= skid;
    end
  end

  // Accepted-request counter; wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_count <= '0;
    end else if (accept) begin
      xfer_count <= xfer_count + CNT_W'(1);
    end else begin
      xfer_count <= xfer_count;
    end
  end

endmodule

// File: tb/tb_pixel_operand_sel_pipe.sv
// Self-checking bench for pixel_operand_sel_pipe (default parameters).
// Inputs are driven on the falling edge, the reference model steps on the
// rising edge, and DUT outputs are compared on the following falling edge.
module tb_pixel_operand_sel_pipe;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    sel_mode;
  logic [W-1:0]  pixel_in;
  logic [W-1:0]  immediate;
  logic [W-1:0]  fwd_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  operand_out;
  logic [15:0]   xfer_count;

  int checks = 0;
  int errors = 0;

  // Reference model: a queue of stored vectors, a counter, and a flag
  // that is clear until the first clock edge after reset release.
  logic [W-1:0]  mq[$];
  logic [15:0]   m_cnt;
  logic          m_en;

  typedef struct {
    logic [1:0]   mode;
    logic [W-1:0] pix;
    logic [W-1:0] imm;
    logic [W-1:0] fwd;
    logic [W-1:0] exp;
  } vec_t;

  vec_t tbl[6];

  pixel_operand_sel_pipe dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .sel_mode    (sel_mode),
    .pixel_in    (pixel_in),
    .immediate   (immediate),
    .fwd_data    (fwd_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .operand_out (operand_out),
    .xfer_count  (xfer_count)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Operand selection for LANES=4, PIXEL_W=8, IMM_W=32.
  function automatic logic [W-1:0] ref_sel(input logic [1:0] m, input logic [W-1:0] p,
                                           input logic [W-1:0] i, input logic [W-1:0] f);
    case (m)
      2'b00:   return p;
      2'b01:   return {4{i[7:0]}};
      2'b10:   return i;            // four immediate bytes map one-to-one onto four lanes
      default: return f;
    endcase
  endfunction

  task automatic compare_model();
    chk("in_ready", 32'(in_ready), 32'(m_en && (mq.size() < 2)));
    chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
    if (mq.size() > 0) chk("operand_out", operand_out, mq[0]);
    chk("xfer_count", 32'(xfer_count), 32'(m_cnt));
  endtask

  // One clock cycle: drive (at a falling edge), step model, compare.
  task automatic cycle(input logic v, input logic [1:0] m, input logic [W-1:0] p,
                       input logic [W-1:0] i, input logic [W-1:0] f, input logic ordy);
    logic acc;
    logic drn;
    in_valid  = v;
    sel_mode  = m;
    pixel_in  = p;
    immediate = i;
    fwd_data  = f;
    out_ready = ordy;
    @(posedge clk);
    acc = v && m_en && (mq.size() < 2);
    drn = (mq.size() > 0) && ordy;
    if (drn) void'(mq.pop_front());
    if (acc) begin
      mq.push_back(ref_sel(m, p, i, f));
      m_cnt = m_cnt + 16'd1;
    end
    m_en = 1'b1;
    @(negedge clk);
    compare_model();
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, ordy);
  endtask

  // Asynchronous reset asserted between edges, checked at once, released on a falling edge.
  task automatic do_reset();
    #3;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    chk("rst_xfer_count", 32'(xfer_count), 32'h0);
    chk("rst_operand_out", operand_out, 32'h0);
    mq.delete();
    m_cnt = 16'd0;
    m_en  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rel_in_ready", 32'(in_ready), 32'h0);
  endtask

  initial begin
    logic [15:0] cnt0;

    tbl[0] = '{2'b00, 32'h44332211, 32'hDDCCBBAA, 32'h88776655, 32'h44332211};
    tbl[1] = '{2'b01, 32'h44332211, 32'hDDCCBBAA, 32'h88776655, 32'hAAAAAAAA};
    tbl[2] = '{2'b10, 32'h44332211, 32'hDDCCBBAA, 32'h88776655, 32'hDDCCBBAA};
    tbl[3] = '{2'b11, 32'h44332211, 32'hDDCCBBAA, 32'h88776655, 32'h88776655};
    tbl[4] = '{2'b01, 32'h0, 32'h12345678, 32'hFFFFFFFF, 32'h78787878};
    tbl[5] = '{2'b10, 32'hFFFFFFFF, 32'h01020304, 32'h0, 32'h01020304};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    sel_mode  = 2'b00;
    pixel_in  = '0;
    immediate = '0;
    fwd_data  = '0;
    mq.delete();
    m_cnt = 16'd0;
    m_en  = 1'b0;

    // T1 power-on reset values, in_ready rises one cycle after release.
    repeat (3) @(negedge clk);
    chk("por_out_valid", 32'(out_valid), 32'h0);
    chk("por_in_ready", 32'(in_ready), 32'h0);
    chk("por_xfer_count", 32'(xfer_count), 32'h0);
    chk("por_operand_out", operand_out, 32'h0);
    rst_n = 1'b1;
    idle(1'b1);
    chk("t1_in_ready_after_release", 32'(in_ready), 32'h1);

    // T2 mode table: each vector visible one cycle after accept.
    for (int k = 0; k < 6; k++) begin
      cycle(1'b1, tbl[k].mode, tbl[k].pix, tbl[k].imm, tbl[k].fwd, 1'b1);
      chk("t2_out_valid", 32'(out_valid), 32'h1);
      chk("t2_operand", operand_out, tbl[k].exp);
      idle(1'b1);
      chk("t2_drained", 32'(out_valid), 32'h0);
    end

    // T3 stall: A and B accepted, C waits while full, then in-order delivery.
    cnt0 = m_cnt;
    cycle(1'b1, 2'b00, 32'hA0A0A0A1, 32'h0, 32'h0, 1'b0);
    cycle(1'b1, 2'b00, 32'hB0B0B0B2, 32'h0, 32'h0, 1'b0);
    chk("t3_full_in_ready", 32'(in_ready), 32'h0);
    chk("t3_head_a", operand_out, 32'hA0A0A0A1);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 2'b00, 32'hC0C0C0C3, 32'h0, 32'h0, 1'b0);
      chk("t3_hold_a", operand_out, 32'hA0A0A0A1);
      chk("t3_hold_in_ready", 32'(in_ready), 32'h0);
    end
    cycle(1'b1, 2'b00, 32'hC0C0C0C3, 32'h0, 32'h0, 1'b1);
    chk("t3_head_b", operand_out, 32'hB0B0B0B2);
    chk("t3_ready_back", 32'(in_ready), 32'h1);
    chk("t3_c_not_yet", 32'(xfer_count), 32'(cnt0 + 16'd2));
    cycle(1'b1, 2'b00, 32'hC0C0C0C3, 32'h0, 32'h0, 1'b1);
    chk("t3_head_c", operand_out, 32'hC0C0C0C3);
    chk("t3_count", 32'(xfer_count), 32'(cnt0 + 16'd3));
    idle(1'b1);
    chk("t3_empty", 32'(out_valid), 32'h0);

    // T5 sampling: inputs changed after accept must not alter stored entries.
    cycle(1'b1, 2'b00, 32'h11111111, 32'h0, 32'h0, 1'b0);
    cycle(1'b0, 2'b00, 32'h22222222, 32'h0, 32'h0, 1'b0);
    cycle(1'b1, 2'b11, 32'h33333333, 32'h0, 32'h5A5A5A5A, 1'b0);
    cycle(1'b0, 2'b11, 32'h44444444, 32'h0, 32'hA5A5A5A5, 1'b0);
    chk("t5_head_kept", operand_out, 32'h11111111);
    idle(1'b1);
    chk("t5_skid_kept", operand_out, 32'h5A5A5A5A);
    idle(1'b1);

    // T4 streaming: one transfer per cycle, buffer stays at one entry.
    cnt0 = m_cnt;
    for (int k = 0; k < 100; k++) begin
      cycle(1'b1, 2'($urandom_range(0, 3)), $urandom, $urandom, $urandom, 1'b1);
      chk("t4_in_ready", 32'(in_ready), 32'h1);
      chk("t4_out_valid", 32'(out_valid), 32'h1);
    end
    chk("t4_count", 32'(xfer_count), 32'(cnt0 + 16'd100));
    idle(1'b1);

    // Randomized traffic against the model, with a reset mid-stream (T1).
    for (int k = 0; k < 3000; k++) begin
      if (k == 1500) begin
        do_reset();
        idle(1'b0);
        chk("t1_mid_ready", 32'(in_ready), 32'h1);
      end
      cycle(($urandom_range(0, 9) < 7), 2'($urandom_range(0, 3)), $urandom, $urandom, $urandom,
            ($urandom_range(0, 9) < 6));
    end

    // T6 counter wrap.
    do_reset();
    idle(1'b1);
    for (int k = 0; k < 65535; k++) begin
      cycle(1'b1, 2'b00, k, 32'h0, 32'h0, 1'b1);
    end
    chk("t6_count_max", 32'(xfer_count), 32'h0000FFFF);
    cycle(1'b1, 2'b00, 32'h0, 32'h0, 32'h0, 1'b1);
    chk("t6_count_wrap", 32'(xfer_count), 32'h00000000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
